// File: rtl/bup_pio_pkg.sv
// Shared definitions for the board-update-portal PIO: register word addresses and edge-capture codes.
package bup_pio_pkg;

  localparam int BUS_WIDTH     = 32;
  localparam int BLINK_DIV_W   = 16;

  localparam logic [2:0] ADDR_OUT      = 3'd0;
  localparam logic [2:0] ADDR_IN       = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK  = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP  = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR   = 3'd5;
  localparam logic [2:0] ADDR_BLINKEN  = 3'd6;
  localparam logic [2:0] ADDR_BLINKDIV = 3'd7;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/bup_avalon_pio_irq_if.sv
// Avalon-MM slave bus bundle for the PIO (system clock domain, zero wait states).
interface bup_avalon_pio_irq_if;
  import bup_pio_pkg::*;

  // A write is chipselect & ~write_n sampled at a clk edge; there is no waitrequest, so every
  // transfer completes in that cycle. readdata is combinational from address/chipselect.
  logic [2:0]           address;
  logic                 chipselect;
  logic                 write_n;
  logic [BUS_WIDTH-1:0] writedata;
  logic [BUS_WIDTH-1:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/bup_pio_sync_edge.sv
// Input synchroniser chain plus one history flop; emits the synchronised value and a one-cycle
// edge pulse selected by EDGE_TYPE (rise, fall or any).
module bup_pio_sync_edge
  import bup_pio_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] in_i,
  output logic [DATA_WIDTH-1:0] sync_val_o,
  output logic [DATA_WIDTH-1:0] edge_pulse_o
);

  logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_q;
  logic [DATA_WIDTH-1:0]                  prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_val_o = sync_q[SYNC_STAGES-1];

  always_comb begin
    edge_pulse_o = sync_val_o & ~prev_q;
    case (EDGE_TYPE)
      EDGE_FALL: edge_pulse_o = ~sync_val_o & prev_q;
      EDGE_ANY:  edge_pulse_o = sync_val_o ^ prev_q;
      default:   edge_pulse_o = sync_val_o & ~prev_q;
    endcase
  end

endmodule

// File: rtl/bup_avalon_pio_irq.sv
// Avalon-MM PIO with atomic set/clear outputs, synchronised inputs, edge capture and masked IRQ.
// Optional LED blink prescaler is built when BUP_PIO_BLINK_EN is defined.
module bup_avalon_pio_irq
  import bup_pio_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] OUT_RESET   = '0,
  parameter int                    SYNC_STAGES = 2,
  parameter int                    EDGE_TYPE   = EDGE_RISE
) (
  input  logic                   clk,
  input  logic                   reset_n,
  bup_avalon_pio_irq_if.slave    bus,
  input  logic [DATA_WIDTH-1:0]  in_port,
  output logic [DATA_WIDTH-1:0]  out_port,
  output logic                   irq
);

  logic                  wr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] sync_val, edge_pulse;
  logic [DATA_WIDTH-1:0] out_q, out_d, mask_q, mask_d, cap_q, cap_d;
  logic [BUS_WIDTH-1:0]  rd_blinken, rd_blinkdiv, rdata;
  logic                  unused_writedata;

  assign wr               = bus.chipselect & ~bus.write_n;
  assign wdata            = bus.writedata[DATA_WIDTH-1:0];
  assign unused_writedata = ^bus.writedata;

  bup_pio_sync_edge #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_sync_edge (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_i         (in_port),
    .sync_val_o   (sync_val),
    .edge_pulse_o (edge_pulse)
  );

  always_comb begin
    out_d  = out_q;
    mask_d = mask_q;
    cap_d  = cap_q;
    if (wr) begin
      case (bus.address)
        ADDR_OUT:     out_d  = wdata;
        ADDR_OUTSET:  out_d  = out_q | wdata;
        ADDR_OUTCLR:  out_d  = out_q & ~wdata;
        ADDR_IRQMASK: mask_d = wdata;
        ADDR_EDGECAP: cap_d  = cap_q & ~wdata;
        default:      ;
      endcase
    end
    // A fresh edge is ORed in after the W1C so a coincident set is never lost.
    cap_d = cap_d | edge_pulse;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q  <= OUT_RESET;
      mask_q <= '0;
      cap_q  <= '0;
    end else begin
      out_q  <= out_d;
      mask_q <= mask_d;
      cap_q  <= cap_d;
    end
  end

  assign irq = |(cap_q & mask_q);

`ifdef BUP_PIO_BLINK_EN
  logic [DATA_WIDTH-1:0]  blink_en_q, blink_en_d;
  logic [BLINK_DIV_W-1:0] blink_div_q, blink_div_d, presc_q, presc_d;
  logic                   phase_q, phase_d;

  always_comb begin
    blink_en_d  = blink_en_q;
    blink_div_d = blink_div_q;
    presc_d     = presc_q + 1'b1;
    phase_d     = phase_q;
    if (presc_q == blink_div_q) begin
      presc_d = '0;
      phase_d = ~phase_q;
    end
    if (wr && bus.address == ADDR_BLINKEN) blink_en_d = wdata;
    // Reprogramming the divider restarts the count but leaves the phase where it is.
    if (wr && bus.address == ADDR_BLINKDIV) begin
      blink_div_d = bus.writedata[BLINK_DIV_W-1:0];
      presc_d     = '0;
      phase_d     = phase_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_en_q  <= '0;
      blink_div_q <= '0;
      presc_q     <= '0;
      phase_q     <= 1'b0;
    end else begin
      blink_en_q  <= blink_en_d;
      blink_div_q <= blink_div_d;
      presc_q     <= presc_d;
      phase_q     <= phase_d;
    end
  end

  assign out_port    = out_q & (~blink_en_q | {DATA_WIDTH{phase_q}});
  assign rd_blinken  = BUS_WIDTH'(blink_en_q);
  assign rd_blinkdiv = BUS_WIDTH'(blink_div_q);
`else
  assign out_port    = out_q;
  assign rd_blinken  = '0;
  assign rd_blinkdiv = '0;
`endif

  always_comb begin
    rdata = '0;
    if (bus.chipselect) begin
      case (bus.address)
        ADDR_OUT:      rdata = BUS_WIDTH'(out_q);
        ADDR_IN:       rdata = BUS_WIDTH'(sync_val);
        ADDR_IRQMASK:  rdata = BUS_WIDTH'(mask_q);
        ADDR_EDGECAP:  rdata = BUS_WIDTH'(cap_q);
        ADDR_BLINKEN:  rdata = rd_blinken;
        ADDR_BLINKDIV: rdata = rd_blinkdiv;
        default:       rdata = '0;
      endcase
    end
  end

  assign bus.readdata = rdata;

endmodule

// File: tb/tb_bup_avalon_pio_irq.sv
// Bench for bup_avalon_pio_irq: a rising-edge and an any-edge instance share one bus stimulus and
// are checked against a cycle-level reference model of the register map.
module tb_bup_avalon_pio_irq;
  import bup_pio_pkg::*;

  localparam int         DW      = 8;
  localparam int         S       = 2;
  localparam logic [7:0] OUT_RST = 8'hA5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [2:0]  b_addr;
  logic        b_cs, b_wn;
  logic [31:0] b_wd;
  logic [7:0]  in_port, out0, out2;
  logic        irq0, irq2;

  bup_avalon_pio_irq_if bus0();
  bup_avalon_pio_irq_if bus2();

  assign bus0.address = b_addr; assign bus0.chipselect = b_cs;
  assign bus0.write_n = b_wn;   assign bus0.writedata  = b_wd;
  assign bus2.address = b_addr; assign bus2.chipselect = b_cs;
  assign bus2.write_n = b_wn;   assign bus2.writedata  = b_wd;

  bup_avalon_pio_irq #(.DATA_WIDTH(DW), .OUT_RESET(OUT_RST), .SYNC_STAGES(S), .EDGE_TYPE(EDGE_RISE))
    dut0 (.clk(clk), .reset_n(rst_n), .bus(bus0.slave), .in_port(in_port), .out_port(out0), .irq(irq0));
  bup_avalon_pio_irq #(.DATA_WIDTH(DW), .OUT_RESET(OUT_RST), .SYNC_STAGES(S), .EDGE_TYPE(EDGE_ANY))
    dut2 (.clk(clk), .reset_n(rst_n), .bus(bus2.slave), .in_port(in_port), .out_port(out2), .irq(irq2));

  int n_run = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  // ---------------- reference model ----------------
  // hist holds in_port as seen at each clk edge; the synchronised value is the sample from S edges back.
  logic [7:0]  m_out, m_mask, m_cap0, m_cap2, m_ben;
  logic [15:0] m_div, m_presc;
  logic        m_phase;
  logic [7:0]  hist[$];

  always @(posedge clk or negedge rst_n) begin : model
    logic       wr;
    logic [7:0] s, p, clr;
    if (!rst_n) begin
      m_out = OUT_RST; m_mask = '0; m_cap0 = '0; m_cap2 = '0;
      m_ben = '0; m_div = '0; m_presc = '0; m_phase = 1'b0;
      hist.delete();
      for (int i = 0; i <= S; i++) hist.push_back(8'h00);
    end else begin
      wr  = b_cs & ~b_wn;
      s   = hist[hist.size()-S];
      p   = hist[hist.size()-S-1];
      clr = (wr && b_addr == ADDR_EDGECAP) ? b_wd[7:0] : 8'h00;
      m_cap0 = (m_cap0 & ~clr) | (s & ~p);
      m_cap2 = (m_cap2 & ~clr) | (s ^ p);
      if (wr && b_addr == ADDR_BLINKDIV) m_presc = '0;
      else if (m_presc == m_div) begin m_presc = '0; m_phase = ~m_phase; end
      else m_presc = m_presc + 16'd1;
      if (wr) begin
        case (b_addr)
          ADDR_OUT:      m_out  = b_wd[7:0];
          ADDR_OUTSET:   m_out  = m_out | b_wd[7:0];
          ADDR_OUTCLR:   m_out  = m_out & ~b_wd[7:0];
          ADDR_IRQMASK:  m_mask = b_wd[7:0];
          ADDR_BLINKEN:  m_ben  = b_wd[7:0];
          ADDR_BLINKDIV: m_div  = b_wd[15:0];
          default: ;
        endcase
      end
      hist.push_back(in_port);
      if (hist.size() > 8) void'(hist.pop_front());
    end
  end

  function automatic logic [31:0] exp_rd(input bit any, input logic [2:0] a);
    case (a)
      ADDR_OUT:     return {24'h0, m_out};
      ADDR_IN:      return {24'h0, hist[hist.size()-S]};
      ADDR_IRQMASK: return {24'h0, m_mask};
      ADDR_EDGECAP: return {24'h0, any ? m_cap2 : m_cap0};
`ifdef BUP_PIO_BLINK_EN
      ADDR_BLINKEN:  return {24'h0, m_ben};
      ADDR_BLINKDIV: return {16'h0, m_div};
`endif
      default:      return 32'h0;
    endcase
  endfunction

  function automatic logic [7:0] exp_out();
`ifdef BUP_PIO_BLINK_EN
    return m_out & (~m_ben | {8{m_phase}});
`else
    return m_out;
`endif
  endfunction

  function automatic logic exp_irq(input bit any);
    return |((any ? m_cap2 : m_cap0) & m_mask);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    b_cs = 1'b1; b_wn = 1'b0; b_addr = a; b_wd = d;
    @(negedge clk);
    b_cs = 1'b0; b_wn = 1'b1; b_wd = '0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] r0, output logic [31:0] r2);
    @(negedge clk);
    b_cs = 1'b1; b_wn = 1'b1; b_addr = a;
    #1;
    r0 = bus0.readdata; r2 = bus2.readdata;
    b_cs = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] r0, r2, e;
    rst_n = 1'b0; b_cs = 1'b0; b_wn = 1'b1; b_addr = '0; b_wd = '0; in_port = '0;
    repeat (3) @(posedge clk);
    #1;
    n_run++; if (out0 !== OUT_RST) begin n_fail++; $display("FAIL reset_out0: got %h expected %h", out0, OUT_RST); end
    n_run++; if (out2 !== OUT_RST) begin n_fail++; $display("FAIL reset_out2: got %h expected %h", out2, OUT_RST); end
    n_run++; if (irq0 !== 1'b0 || irq2 !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b%b expected 00", irq0, irq2); end
    @(negedge clk); rst_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), r0, r2);
      e = (a == 0) ? 32'h0000_00A5 : 32'h0;
      n_run++; if (r0 !== e || r2 !== e) begin n_fail++; $display("FAIL reset_rd_a%0d: got %h/%h expected %h", a, r0, r2, e); end
    end
  endtask

  task automatic test_set_clr();
    logic [31:0] r0, r2;
    bus_write(ADDR_OUT, 32'h0F);
    bus_write(ADDR_OUTSET, 32'hF0);
    bus_write(ADDR_OUTCLR, 32'h03);
    bus_read(ADDR_OUT, r0, r2);
    n_run++; if (r0 !== 32'hFC || r2 !== 32'hFC) begin n_fail++; $display("FAIL setclr_rd_out: got %h/%h expected fc", r0, r2); end
    n_run++; if (out0 !== 8'hFC || out2 !== 8'hFC) begin n_fail++; $display("FAIL setclr_pins: got %h/%h expected fc", out0, out2); end
    bus_read(ADDR_OUTSET, r0, r2);
    n_run++; if (r0 !== 32'h0 || r2 !== 32'h0) begin n_fail++; $display("FAIL setclr_rd_outset: got %h/%h expected 0", r0, r2); end
    bus_read(ADDR_OUTCLR, r0, r2);
    n_run++; if (r0 !== 32'h0 || r2 !== 32'h0) begin n_fail++; $display("FAIL setclr_rd_outclr: got %h/%h expected 0", r0, r2); end
  endtask

  task automatic test_edge_capture();
    logic [31:0] r0, r2;
    int lat;
    bus_write(ADDR_IRQMASK, 32'h01);
    @(negedge clk); in_port[0] = 1'b1;
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      @(posedge clk); #1;
      if (irq0 === 1'b1) lat = i;
    end
    n_run++; if (lat != S + 1) begin n_fail++; $display("FAIL edge_latency: got %0d expected %0d", lat, S + 1); end
    n_run++; if (irq2 !== 1'b1) begin n_fail++; $display("FAIL edge_irq_any: got %b expected 1", irq2); end
    bus_read(ADDR_EDGECAP, r0, r2);
    n_run++; if (r0 !== 32'h01 || r2 !== 32'h01) begin n_fail++; $display("FAIL edge_rd_cap: got %h/%h expected 01", r0, r2); end
    bus_write(ADDR_EDGECAP, 32'h01);
    n_run++; if (irq0 !== 1'b0 || irq2 !== 1'b0) begin n_fail++; $display("FAIL edge_w1c_irq: got %b%b expected 00", irq0, irq2); end
  endtask

  task automatic test_set_wins();
    logic [31:0] r0, r2;
    @(negedge clk); in_port[0] = 1'b0;
    repeat (5) @(posedge clk);
    bus_write(ADDR_EDGECAP, 32'hFF);
    @(negedge clk); in_port[0] = 1'b1;
    @(posedge clk); @(posedge clk);
    bus_write(ADDR_EDGECAP, 32'h01);
    bus_read(ADDR_EDGECAP, r0, r2);
    n_run++; if (r0 !== 32'h01 || r2 !== 32'h01) begin n_fail++; $display("FAIL setwins_cap: got %h/%h expected 01", r0, r2); end
    n_run++; if (irq0 !== 1'b1 || irq2 !== 1'b1) begin n_fail++; $display("FAIL setwins_irq: got %b%b expected 11", irq0, irq2); end
  endtask

  task automatic test_any_edge();
    logic [31:0] r0, r2;
    bus_write(ADDR_IRQMASK, 32'h00);
    @(negedge clk); in_port[3] = 1'b1;
    repeat (5) @(posedge clk);
    bus_write(ADDR_EDGECAP, 32'hFF);
    @(negedge clk); in_port[3] = 1'b0;
    repeat (5) @(posedge clk);
    bus_read(ADDR_EDGECAP, r0, r2);
    n_run++; if (r0 !== 32'h00) begin n_fail++; $display("FAIL any_fall_rise_inst: got %h expected 00", r0); end
    n_run++; if (r2 !== 32'h08) begin n_fail++; $display("FAIL any_fall_any_inst: got %h expected 08", r2); end
    @(negedge clk); in_port[3] = 1'b1;
    repeat (5) @(posedge clk);
    bus_read(ADDR_EDGECAP, r0, r2);
    n_run++; if (r0 !== 32'h08 || r2 !== 32'h08) begin n_fail++; $display("FAIL any_retained: got %h/%h expected 08", r0, r2); end
    n_run++; if (irq0 !== 1'b0 || irq2 !== 1'b0) begin n_fail++; $display("FAIL any_masked_irq: got %b%b expected 00", irq0, irq2); end
  endtask

  task automatic test_blink();
    logic [31:0] r0, r2;
`ifdef BUP_PIO_BLINK_EN
    logic prev;
    int last, n_tog;
    bus_write(ADDR_OUT, 32'hFF);
    bus_write(ADDR_BLINKEN, 32'h01);
    bus_write(ADDR_BLINKDIV, 32'h3);
    prev = out0[0]; last = -1; n_tog = 0;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      n_run++; if (out0 !== exp_out()) begin n_fail++; $display("FAIL blink_pins_c%0d: got %h expected %h", i, out0, exp_out()); end
      n_run++; if (out0[7:1] !== 7'h7F) begin n_fail++; $display("FAIL blink_steady_c%0d: got %h expected 7f", i, out0[7:1]); end
      if (out0[0] !== prev) begin
        if (last >= 0) begin
          n_run++; if (i - last != 4) begin n_fail++; $display("FAIL blink_period: got %0d expected 4", i - last); end
        end
        last = i; n_tog++;
      end
      prev = out0[0];
    end
    n_run++; if (n_tog < 5) begin n_fail++; $display("FAIL blink_toggles: got %0d expected >=5", n_tog); end
    bus_read(ADDR_BLINKDIV, r0, r2);
    n_run++; if (r0 !== 32'h3) begin n_fail++; $display("FAIL blink_rd_div: got %h expected 3", r0); end
`else
    bus_write(ADDR_BLINKEN, 32'hFF);
    bus_write(ADDR_BLINKDIV, 32'h3);
    bus_read(ADDR_BLINKEN, r0, r2);
    n_run++; if (r0 !== 32'h0 || r2 !== 32'h0) begin n_fail++; $display("FAIL noblink_rd_en: got %h/%h expected 0", r0, r2); end
    bus_read(ADDR_BLINKDIV, r0, r2);
    n_run++; if (r0 !== 32'h0 || r2 !== 32'h0) begin n_fail++; $display("FAIL noblink_rd_div: got %h/%h expected 0", r0, r2); end
`endif
  endtask

  task automatic test_random();
    logic [31:0] r0, r2, e;
    logic [2:0]  a;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) in_port = 8'($urandom);
      a = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) begin
        bus_write(a, (a == ADDR_BLINKDIV) ? 32'($urandom_range(0, 5)) : $urandom);
      end else begin
        bus_read(a, r0, r2);
        exp_q.push_back(exp_rd(1'b0, a));
        exp_q.push_back(exp_rd(1'b1, a));
        e = exp_q.pop_front();
        n_run++; if (r0 !== e) begin n_fail++; $display("FAIL rand_rd0_a%0d_i%0d: got %h expected %h", a, i, r0, e); end
        e = exp_q.pop_front();
        n_run++; if (r2 !== e) begin n_fail++; $display("FAIL rand_rd2_a%0d_i%0d: got %h expected %h", a, i, r2, e); end
        n_run++; if (out0 !== exp_out() || out2 !== exp_out()) begin n_fail++; $display("FAIL rand_pins_i%0d: got %h/%h expected %h", i, out0, out2, exp_out()); end
        n_run++; if (irq0 !== exp_irq(1'b0) || irq2 !== exp_irq(1'b1)) begin n_fail++; $display("FAIL rand_irq_i%0d: got %b%b expected %b%b", i, irq0, irq2, exp_irq(1'b0), exp_irq(1'b1)); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r0, r2, e;
    bus_write(ADDR_OUT, 32'h3C);
    bus_write(ADDR_IRQMASK, 32'hFF);
`ifdef BUP_PIO_BLINK_EN
    bus_write(ADDR_BLINKEN, 32'hFF);
    bus_write(ADDR_BLINKDIV, 32'h1);
`endif
    @(negedge clk); in_port = ~in_port;
    repeat (4) @(posedge clk);
    n_run++; if (irq2 !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_irq: got %b expected 1", irq2); end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    n_run++; if (out0 !== OUT_RST || out2 !== OUT_RST) begin n_fail++; $display("FAIL midrst_pins: got %h/%h expected a5", out0, out2); end
    n_run++; if (irq0 !== 1'b0 || irq2 !== 1'b0) begin n_fail++; $display("FAIL midrst_irq: got %b%b expected 00", irq0, irq2); end
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), r0, r2);
      e = (a == 0) ? 32'h0000_00A5 : 32'h0;
      n_run++; if (r0 !== e || r2 !== e) begin n_fail++; $display("FAIL midrst_rd_a%0d: got %h/%h expected %h", a, r0, r2, e); end
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_set_clr();
    test_edge_capture();
    test_set_wins();
    test_any_edge();
    test_blink();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
